exe_muldiv: RTL and testbench

- Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the single-cycle integer ALU in the EXE stage.
- Parametrised in data width; iterative radix-2 datapath for both multiply and divide.
- Valid/ready handshake on input; registered one-cycle result pulse toward exe_mem with the same writeback fields as the ALU path; stall_o freezes upstream stages while busy; flush_i aborts work.

---
 rtl/exe_muldiv.sv | 216 +++++++++++++++++++++
 tb/tb_exe_muldiv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// -----------------------------------------------------------------------------
// exe_muldiv -- multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) that sits beside the single-cycle ALU in EXE.
//
// Datapath: one shared 2*XLEN accumulator.
//   multiply : radix-2 shift-add, one multiplier bit per cycle
//   divide   : restoring shift-subtract, one quotient bit per cycle
// Signed operands are turned into magnitudes on accept and the final result
// is negated on the way out.
//
// FSM: IDLE -> CALC (XLEN cycles) -> DONE (one-cycle result pulse) -> IDLE.
// Divide-by-zero and signed overflow skip CALC and go straight to DONE.
//
// Optional build macro:
//   EXE_MULDIV_FAST_MUL_EN  multiplies use a combinational product and go
//                           IDLE -> DONE directly; divides are unchanged.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   valid_i      request present
//   op_i[2:0]    RV32M funct3
//   op1_i/op2_i  rs1 / rs2 values (XLEN)
//   reg_waddr_i  destination register
//   flush_i      abort current/incoming request
//   ready_o      unit can accept (comb.)
//   stall_o      hold upstream pipeline (comb.)
//   valid_o      result valid pulse (reg., gated by flush_i)
//   reg_waddr_o  destination (reg.)
//   reg_we_o     write enable, equals valid_o
//   reg_wdata_o  result (reg.)
// -----------------------------------------------------------------------------
module exe_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_we_o,
  output logic [XLEN-1:0] reg_wdata_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [4:0]        r_waddr;
  logic              r_valid;
  logic [4:0]        r_waddr_out;
  logic [XLEN-1:0]   r_wdata;

  // ---------------- request decode (IDLE) ----------------
  logic            w_accept, w_s1, w_s2, w_neg1, w_neg2, w_neg;
  logic            w_div_zero, w_div_ovf, w_special, w_fast;
  logic [XLEN-1:0] w_mag1, w_mag2, w_special_res, w_fast_res, w_in_res;

  assign ready_o  = (r_state == S_IDLE) && !rst_i;
  assign w_accept = ready_o && valid_i && !flush_i;
  assign stall_o  = !rst_i && (((r_state == S_IDLE) && valid_i && !flush_i) ||
                               (r_state == S_CALC));

  // MUL treats operands as unsigned: the low half is sign-independent.
  assign w_s1   = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
  assign w_s2   = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
  assign w_neg1 = w_s1 && op1_i[XLEN-1];
  assign w_neg2 = w_s2 && op2_i[XLEN-1];
  assign w_mag1 = w_neg1 ? -op1_i : op1_i;
  assign w_mag2 = w_neg2 ? -op2_i : op2_i;
  // Remainder takes the dividend's sign; product/quotient take the XOR.
  assign w_neg  = (op_i == 3'b110) ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_div_zero = op_i[2] && (op2_i == '0);
  assign w_div_ovf  = ((op_i == 3'b100) || (op_i == 3'b110)) &&
                      (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign w_special  = w_div_zero || w_div_ovf;

  always_comb begin
    w_special_res = '0;
    if (op_i[1]) w_special_res = w_div_zero ? op1_i : '0;    // REM/REMU
    else         w_special_res = w_div_zero ? '1 : op1_i;    // DIV/DIVU
  end

`ifdef EXE_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_ext1, w_ext2, w_fprod;
  assign w_ext1  = {{XLEN{w_s1 && op1_i[XLEN-1]}}, op1_i};
  assign w_ext2  = {{XLEN{w_s2 && op2_i[XLEN-1]}}, op2_i};
  assign w_fprod = w_ext1 * w_ext2;
  assign w_fast  = !op_i[2];
  assign w_fast_res = (op_i == 3'b000) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
  assign w_fast     = 1'b0;
  assign w_fast_res = '0;
`endif

  assign w_in_res = w_special ? w_special_res : w_fast_res;

  // ---------------- iteration step (CALC) ----------------
  logic [XLEN-1:0]   w_acc_hi, w_acc_lo, w_q_fin, w_r_fin;
  logic [XLEN:0]     w_msum, w_dshift, w_ddiff;
  logic              w_dok;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_acc_next, w_prod_fin;
  logic [XLEN-1:0]   w_calc_res;

  assign w_acc_hi = r_acc[2*XLEN-1:XLEN];
  assign w_acc_lo = r_acc[XLEN-1:0];

  // Multiply: low half holds the multiplier, consumed LSB first; the sum
  // keeps its carry and everything shifts right one place.
  assign w_msum     = {1'b0, w_acc_hi} + (w_acc_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_msum, w_acc_lo[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half shifts the
  // dividend out and the quotient in. Bit XLEN of the difference is the
  // borrow, which decides whether to restore.
  assign w_dshift   = {w_acc_hi, w_acc_lo[XLEN-1]};
  assign w_ddiff    = w_dshift - {1'b0, r_b};
  assign w_dok      = !w_ddiff[XLEN];
  assign w_div_next = {(w_dok ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0]),
                       w_acc_lo[XLEN-2:0], w_dok};

  assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

  assign w_prod_fin = r_neg ? -w_acc_next : w_acc_next;
  assign w_q_fin    = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_r_fin    = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_calc_res = '0;
    case (r_op)
      3'b000:                 w_calc_res = w_prod_fin[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_calc_res = w_prod_fin[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_calc_res = w_q_fin;
      default:                w_calc_res = w_r_fin;
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_b         <= '0;
      r_acc       <= '0;
      r_waddr     <= '0;
      r_valid     <= 1'b0;
      r_waddr_out <= '0;
      r_wdata     <= '0;
    end else begin
      // Output registers are zero except in the single DONE cycle.
      r_valid     <= 1'b0;
      r_waddr_out <= '0;
      r_wdata     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op_i;
            r_neg   <= w_neg;
            r_b     <= w_mag2;
            r_acc   <= {{XLEN{1'b0}}, w_mag1};
            r_waddr <= reg_waddr_i;
            r_cnt   <= '0;
            if (w_special || w_fast) begin
              r_state     <= S_DONE;
              r_valid     <= 1'b1;
              r_waddr_out <= reg_waddr_i;
              r_wdata     <= w_in_res;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN-1)) begin
              r_state     <= S_DONE;
              r_valid     <= 1'b1;
              r_waddr_out <= r_waddr;
              r_wdata     <= w_calc_res;
            end
          end
        end
        default: r_state <= S_IDLE;   // DONE (flushed or not) returns to IDLE
      endcase
    end
  end

  // A flush in DONE kills the write in the same cycle.
  assign valid_o     = r_valid && !flush_i;
  assign reg_we_o    = r_valid && !flush_i;
  assign reg_waddr_o = r_waddr_out;
  assign reg_wdata_o = r_wdata;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv (XLEN=32). Latency is counted in clock edges
// with the accept edge itself counted as edge 1.
module tb_exe_muldiv;

  localparam int XLEN    = 32;
  localparam int LAT_N   = XLEN + 1;
  localparam int LAT_SP  = 1;
`ifdef EXE_MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = XLEN + 1;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op1_i, op2_i;
  logic [4:0]      reg_waddr_i;
  logic            flush_i;
  logic            ready_o, stall_o, valid_o, reg_we_o;
  logic [4:0]      reg_waddr_o;
  logic [XLEN-1:0] reg_wdata_o;

  int n_checks = 0;
  int n_errors = 0;

  exe_muldiv #(.XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request: drive, accept, wait for the pulse, check all result fields.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; op1_i = a; op2_i = b; reg_waddr_i = wa;
    #1 check({tag, "_ready"}, 64'(ready_o), 64'd1);
    @(posedge clk_i);
    lat = 1; seen = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    while (!seen && lat < 100) begin
      if (valid_o) seen = 1'b1;
      else begin
        @(posedge clk_i); lat++;
        @(negedge clk_i);
      end
    end
    check({tag, "_lat"},   64'(lat),         64'(exp_lat));
    check({tag, "_data"},  64'(reg_wdata_o), 64'(exp));
    check({tag, "_waddr"}, 64'(reg_waddr_o), 64'(wa));
    check({tag, "_we"},    64'(reg_we_o),    64'd1);
    $display("op %s: a=0x%08h b=0x%08h -> 0x%08h after %0d edges", tag, a, b, reg_wdata_o, lat);
    @(negedge clk_i);
    check({tag, "_pulse1"}, 64'({valid_o, reg_we_o}), 64'd0);
    check({tag, "_idle"},   64'(ready_o), 64'd1);
  endtask

  initial begin
    int pulses;
    int e1, e2, edge_n, stall_bad;
    logic [31:0] res1, res2;

    rst_i = 1'b1; valid_i = 1'b0; op_i = '0; op1_i = '0; op2_i = '0;
    reg_waddr_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out", 64'({valid_o, reg_we_o, reg_waddr_o, reg_wdata_o}), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    rst_i = 1'b0;
    #1 check("rst_rel_ready", 64'(ready_o), 64'd1);

    // Multiply family
    run_op("mul",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001, LAT_MUL);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, LAT_MUL);
    run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, LAT_MUL);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, LAT_MUL);
    run_op("mulh2",  3'b001, 32'h80000000, 32'h00000003, 5'd6, 32'hFFFFFFFE, LAT_MUL);

    // Divide family
    run_op("div",  3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, LAT_N);
    run_op("rem",  3'b110, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFF, LAT_N);
    run_op("divu", 3'b101, 32'd7,        32'd2, 5'd5, 32'd3,        LAT_N);
    run_op("remu", 3'b111, 32'd7,        32'd2, 5'd5, 32'd1,        LAT_N);
    run_op("divu_big", 3'b101, 32'hFFFFFFFF, 32'h80000001, 5'd7, 32'd1, LAT_N);

    // Special cases
    run_op("div0",     3'b100, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, LAT_SP);
    run_op("remu0",    3'b111, 32'd5,        32'd0,        5'd9,  32'd5,        LAT_SP);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, LAT_SP);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000, LAT_SP);

    // Reset in the middle of CALC
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; reg_waddr_i = 5'd12;
    @(posedge clk_i);
    @(negedge clk_i); valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("mrst_out", 64'({valid_o, reg_we_o, reg_waddr_o, reg_wdata_o}), 64'd0);
    check("mrst_stall", 64'(stall_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("mrst_ready", 64'(ready_o), 64'd1);
    $display("reset mid-CALC: outputs cleared, ready=%0d", ready_o);
    run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, LAT_N);

    // Flush at CALC cycle 5
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; reg_waddr_i = 5'd13;
    @(posedge clk_i);
    @(negedge clk_i); valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b0;
    check("flush_ready", 64'(ready_o), 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) pulses++;
    end
    check("flush_nopulse", 64'(pulses), 64'd0);
    $display("flush mid-CALC: pulses=%0d", pulses);

    // flush_i together with valid_i in IDLE: not accepted
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; op1_i = 32'd9; op2_i = 32'd3;
    #1 check("fidle_stall", 64'(stall_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("fidle_ready", 64'(ready_o), 64'd1);
    valid_i = 1'b0; flush_i = 1'b0;
    $display("flush with valid in IDLE: ready=%0d", ready_o);

    // Flush in DONE suppresses the pulse combinationally
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'b100; op1_i = 32'd5; op2_i = 32'd0; reg_waddr_i = 5'd14;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b1;
    #1 check("fdone_valid", 64'({valid_o, reg_we_o}), 64'd0);
    @(negedge clk_i); flush_i = 1'b0;
    check("fdone_ready", 64'(ready_o), 64'd1);
    $display("flush in DONE: valid=%0d", valid_o);

    // Back-to-back: MUL 3x4, then DIVU 12/5 held under stall_o
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'b000; op1_i = 32'd3; op2_i = 32'd4; reg_waddr_i = 5'd15;
    @(posedge clk_i);
    edge_n = 1;
    #1 op_i = 3'b101; op1_i = 32'd12; op2_i = 32'd5; reg_waddr_i = 5'd16;
    e1 = 0; e2 = 0; res1 = '0; res2 = '0; stall_bad = 0;
    while (e2 == 0 && edge_n < 200) begin
      @(negedge clk_i);
      if (valid_o) begin
        if (stall_o) stall_bad++;
        if (e1 == 0) begin e1 = edge_n; res1 = reg_wdata_o; end
        else begin e2 = edge_n; res2 = reg_wdata_o; valid_i = 1'b0; end
      end else if (!stall_o) stall_bad++;
      if (e2 == 0) begin
        @(posedge clk_i); edge_n++;
      end
    end
    check("b2b_res1", 64'(res1), 64'd12);
    check("b2b_res2", 64'(res2), 64'd2);
    check("b2b_lat1", 64'(e1), 64'(LAT_MUL));
    check("b2b_lat2", 64'(e2), 64'(LAT_MUL + 1 + LAT_N));
    check("b2b_stall", 64'(stall_bad), 64'd0);
    $display("back-to-back: 0x%0h at edge %0d, 0x%0h at edge %0d", res1, e1, res2, e2);
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
